// File: rtl/quaternion_normalisation_pkg.sv
// Shared width defaults and state encodings for the quaternion normaliser
// and its inverse square root unit.
package quaternion_normalisation_pkg;

  localparam int QN_INPUT_INT_WIDTH     = 2;
  localparam int QN_INPUT_FRACT_WIDTH   = 14;
  localparam int QN_MAG_SQR_INT_WIDTH   = 4;
  localparam int QN_MAG_SQR_FRACT_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MAG      = 3'd1,
    ST_ROUND    = 3'd2,
    ST_ISQ_REQ  = 3'd3,
    ST_ISQ_WAIT = 3'd4,
    ST_NORM     = 3'd5,
    ST_DONE     = 3'd6
  } qn_state_e;

  typedef enum logic [1:0] {
    ISQ_IDLE = 2'd0,
    ISQ_BUSY = 2'd1,
    ISQ_OUT  = 2'd2
  } isq_state_e;

endpackage

// File: rtl/quaternion_normalisation_inv_sqrt.sv
// Bit-serial inverse square root: finds the largest y with y^2 * x <= 1.0
// in unsigned fixed point, one result bit per cycle, MSB first.
module inv_sqrt
  import quaternion_normalisation_pkg::*;
#(
  parameter int MAG_SQR_INT_WIDTH   = QN_MAG_SQR_INT_WIDTH,
  parameter int MAG_SQR_FRACT_WIDTH = QN_MAG_SQR_FRACT_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] in_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] out_data
);

  localparam int M  = MAG_SQR_INT_WIDTH + MAG_SQR_FRACT_WIDTH;
  localparam int PW = 3 * M;
  // y^2 * x carries 3*F fractional bits, so unity sits at bit 3*F
  localparam logic [PW-1:0] ONE_CUBED = {{(PW-1){1'b0}}, 1'b1} << (3 * MAG_SQR_FRACT_WIDTH);

  isq_state_e     state_r, state_next_s;
  logic [M-1:0]   x_r, y_r, bit_r;
  logic [M-1:0]   trial_s;
  logic [2*M-1:0] trial_sqr_s;
  logic [PW-1:0]  trial_prod_s;
  logic           accept_s;

  // tentative result with the current bit set, kept if it does not overshoot
  always_comb begin
    trial_s      = y_r | bit_r;
    trial_sqr_s  = {{M{1'b0}}, trial_s} * {{M{1'b0}}, trial_s};
    trial_prod_s = {{M{1'b0}}, trial_sqr_s} * {{(2*M){1'b0}}, x_r};
    accept_s     = (trial_prod_s <= ONE_CUBED);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ISQ_IDLE;
    else        state_r <= state_next_s;
  end

  // next state and handshake decode
  always_comb begin
    state_next_s = state_r;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state_r)
      ISQ_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next_s = ISQ_BUSY;
        else          state_next_s = ISQ_IDLE;
      end
      ISQ_BUSY: begin
        if (bit_r[0]) state_next_s = ISQ_OUT;
        else          state_next_s = ISQ_BUSY;
      end
      ISQ_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next_s = ISQ_IDLE;
        else           state_next_s = ISQ_OUT;
      end
      default: state_next_s = ISQ_IDLE;
    endcase
  end

  // operand capture and successive approximation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r   <= '0;
      y_r   <= '0;
      bit_r <= '0;
    end else if ((state_r == ISQ_IDLE) && in_valid) begin
      x_r   <= in_data;
      y_r   <= '0;
      bit_r <= {1'b1, {(M-1){1'b0}}};
    end else if (state_r == ISQ_BUSY) begin
      if (accept_s) y_r <= trial_s;
      bit_r <= bit_r >> 1;
    end
  end

  assign out_data = y_r;

endmodule

// File: rtl/quaternion_normalisation.sv
// Normalises a fixed-point quaternion to unit length: sum of squares,
// rounding to the magnitude format, inverse sqrt, then per-component scaling.
module quaternion_normalisation
  import quaternion_normalisation_pkg::*;
#(
  parameter int INPUT_INT_WIDTH     = QN_INPUT_INT_WIDTH,
  parameter int INPUT_FRACT_WIDTH   = QN_INPUT_FRACT_WIDTH,
  parameter int MAG_SQR_INT_WIDTH   = QN_MAG_SQR_INT_WIDTH,
  parameter int MAG_SQR_FRACT_WIDTH = QN_MAG_SQR_FRACT_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             start,
  output logic                                             done,
  input  logic [4*(INPUT_INT_WIDTH+INPUT_FRACT_WIDTH)-1:0] data_in,
  output logic [4*(INPUT_INT_WIDTH+INPUT_FRACT_WIDTH)-1:0] data_out,
  output logic [2:0]                                       debug_state
);

  localparam int W      = INPUT_INT_WIDTH + INPUT_FRACT_WIDTH;
  localparam int M      = MAG_SQR_INT_WIDTH + MAG_SQR_FRACT_WIDTH;
  localparam int MAG_W  = 2 * W + 3;
  localparam int RND_SH = 2 * INPUT_FRACT_WIDTH - MAG_SQR_FRACT_WIDTH;
  localparam int PROD_W = W + M + 1;
  localparam logic [MAG_W:0]    MAG_HALF  = {{MAG_W{1'b0}}, 1'b1} << (RND_SH - 1);
  localparam logic [PROD_W-1:0] PROD_HALF = {{(PROD_W-1){1'b0}}, 1'b1} << (MAG_SQR_FRACT_WIDTH - 1);

  function automatic logic [2*W-1:0] comp_sqr(input logic [W-1:0] c);
    logic [2*W-1:0] ext;
    ext = {{W{c[W-1]}}, c};
    return ext * ext;
  endfunction

  // signed component times unsigned scale, rounded and clamped to W bits
  function automatic logic [W-1:0] norm_comp(input logic [W-1:0] c, input logic [M-1:0] inv);
    logic [PROD_W-1:0] prod, rnd, sh;
    prod = {{(M+1){c[W-1]}}, c} * {{(W+1){1'b0}}, inv};
    rnd  = prod + PROD_HALF;
    sh   = $unsigned($signed(rnd) >>> MAG_SQR_FRACT_WIDTH);
    if ((&sh[PROD_W-1:W-1]) || (~|sh[PROD_W-1:W-1])) return sh[W-1:0];
    else if (sh[PROD_W-1])                             return {1'b1, {(W-1){1'b0}}};
    else                                               return {1'b0, {(W-1){1'b1}}};
  endfunction

  qn_state_e      state_r, state_next_s;
  logic [4*W-1:0] q_r, data_out_r, norm_s;
  logic [MAG_W-1:0] mag_sqr_r, mag_acc_s;
  logic [MAG_W:0] mag_sum_s, mag_sh_s;
  logic [M-1:0]   mag_rnd_s, mag_rnd_r, inv_r;
  logic           done_r;
  logic           isq_in_valid_s, isq_in_ready_s, isq_out_valid_s, isq_out_ready_s;
  logic [M-1:0]   isq_out_data_s;

  // magnitude squared, rounding to the magnitude format, and scaled outputs
  always_comb begin
    mag_acc_s = '0;
    norm_s    = '0;
    for (int i = 0; i < 4; i++) begin
      mag_acc_s = mag_acc_s + {3'b000, comp_sqr(q_r[i*W +: W])};
      norm_s[i*W +: W] = norm_comp(q_r[i*W +: W], inv_r);
    end
    mag_sum_s = {1'b0, mag_sqr_r} + MAG_HALF;
    mag_sh_s  = mag_sum_s >> RND_SH;
    if (|mag_sh_s[MAG_W:M]) mag_rnd_s = '1;
    else                    mag_rnd_s = mag_sh_s[M-1:0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // next state and inverse sqrt handshake
  always_comb begin
    state_next_s    = state_r;
    isq_in_valid_s  = 1'b0;
    isq_out_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_MAG;
        else       state_next_s = ST_IDLE;
      end
      ST_MAG: state_next_s = ST_ROUND;
      ST_ROUND: begin
        if (mag_rnd_s == '0) state_next_s = ST_DONE;
        else                 state_next_s = ST_ISQ_REQ;
      end
      ST_ISQ_REQ: begin
        isq_in_valid_s = 1'b1;
        if (isq_in_ready_s) state_next_s = ST_ISQ_WAIT;
        else                state_next_s = ST_ISQ_REQ;
      end
      ST_ISQ_WAIT: begin
        isq_out_ready_s = 1'b1;
        if (isq_out_valid_s) state_next_s = ST_NORM;
        else                 state_next_s = ST_ISQ_WAIT;
      end
      ST_NORM: state_next_s = ST_DONE;
      ST_DONE: begin
        if (!start) state_next_s = ST_IDLE;
        else        state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // datapath registers and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r        <= '0;
      mag_sqr_r  <= '0;
      mag_rnd_r  <= '0;
      inv_r      <= '0;
      data_out_r <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= (state_next_s == ST_DONE);
      case (state_r)
        ST_IDLE:     if (start) q_r <= data_in;
        ST_MAG:      mag_sqr_r <= mag_acc_s;
        ST_ROUND: begin
          mag_rnd_r <= mag_rnd_s;
          if (mag_rnd_s == '0) data_out_r <= '0;
        end
        ST_ISQ_WAIT: if (isq_out_valid_s) inv_r <= isq_out_data_s;
        ST_NORM:     data_out_r <= norm_s;
        default:     ;
      endcase
    end
  end

  inv_sqrt #(
    .MAG_SQR_INT_WIDTH   (MAG_SQR_INT_WIDTH),
    .MAG_SQR_FRACT_WIDTH (MAG_SQR_FRACT_WIDTH)
  ) u_inv_sqrt (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (isq_in_valid_s),
    .in_ready  (isq_in_ready_s),
    .in_data   (mag_rnd_r),
    .out_valid (isq_out_valid_s),
    .out_ready (isq_out_ready_s),
    .out_data  (isq_out_data_s)
  );

  assign done        = done_r;
  assign data_out    = data_out_r;
  assign debug_state = state_r;

endmodule

// File: tb/tb_quaternion_normalisation.sv
// Self-checking bench: directed vectors, handshake/reset scenarios and random
// quaternions compared against a real-arithmetic normalisation model.
module tb_quaternion_normalisation;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic [2:0]  debug_state;
  int          total = 0;
  int          bad   = 0;

  localparam int MAX_LAT = 48;

  always #5 clk = ~clk;

  quaternion_normalisation dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .done        (done),
    .data_in     (data_in),
    .data_out    (data_out),
    .debug_state (debug_state)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint comp(input logic [63:0] d, input int i);
    logic [15:0] c;
    c = d[i*16 +: 16];
    return longint'($signed(c));
  endfunction

  // floor of 1/sqrt(mr) in Q4.12, i.e. floor(2^18 / sqrt(mr))
  function automatic longint inv_floor(input longint mr);
    real    t;
    longint y;
    t = 262144.0 / $sqrt(real'(mr));
    y = longint'($floor(t));
    while ((y + 1) * (y + 1) * mr <= 64'sd68719476736) y++;
    while (y * y * mr > 64'sd68719476736) y--;
    return y;
  endfunction

  // bump=1 selects the inverse sqrt one LSB above the floor (both are within 1 LSB)
  function automatic logic [63:0] ref_norm(input logic [63:0] din, input bit bump);
    longint      mag, mr, y, p, r;
    logic [63:0] res;
    logic [63:0] rv;
    mag = 0;
    res = '0;
    for (int i = 0; i < 4; i++) mag += comp(din, i) * comp(din, i);
    mr = (mag + 64'sd32768) >>> 16;
    if (mr > 65535) mr = 65535;
    if (mr == 0) return '0;
    y = inv_floor(mr);
    if (y > 65535) y = 65535;
    else if (bump && (y < 65535)) y++;
    for (int i = 0; i < 4; i++) begin
      p = comp(din, i) * y;
      r = (p + 64'sd2048) >>> 12;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      rv = r;
      res[i*16 +: 16] = rv[15:0];
    end
    return res;
  endfunction

  task automatic run_op(input logic [63:0] din, output int lat, output bit saw_isq);
    data_in = din;
    start   = 1'b1;
    saw_isq = 1'b0;
    lat     = 1;
    @(posedge clk); #1;
    data_in = {$urandom, $urandom};
    while (!done && (lat < MAX_LAT)) begin
      if (debug_state == 3'd3) saw_isq = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    @(posedge clk); #1;
    check_val({tag, "_done_low"}, {63'd0, done}, 64'd0);
    check_val({tag, "_idle"}, {61'd0, debug_state}, 64'd0);
  endtask

  task automatic check_op(input string tag, input logic [63:0] din);
    int          lat;
    bit          saw;
    logic [63:0] exp_lo, exp_hi;
    run_op(din, lat, saw);
    exp_lo = ref_norm(din, 1'b0);
    exp_hi = ref_norm(din, 1'b1);
    check_val({tag, "_done"}, {63'd0, done}, 64'd1);
    check_val({tag, "_latency_ok"}, {63'd0, lat <= MAX_LAT}, 64'd1);
    check_val({tag, "_data"}, data_out, (data_out === exp_hi) ? exp_hi : exp_lo);
    release_start(tag);
  endtask

  initial begin
    int          lat;
    bit          saw;
    logic [15:0] c;
    logic [63:0] din;

    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    #12;
    check_val("reset_done", {63'd0, done}, 64'd0);
    check_val("reset_data", data_out, 64'd0);
    check_val("reset_state", {61'd0, debug_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // unit quaternion with tiny perturbations; start held after done
    run_op(64'h4000_FFEE_000A_FFEF, lat, saw);
    check_val("near_unit_done", {63'd0, done}, 64'd1);
    check_val("near_unit_data", data_out, 64'h4000_FFEE_000A_FFEF);
    repeat (5) begin
      @(posedge clk); #1;
      check_val("held_done", {63'd0, done}, 64'd1);
      check_val("held_state", {61'd0, debug_state}, 64'd6);
    end
    release_start("held");

    // zero magnitude bypasses the inverse sqrt
    run_op(64'h0, lat, saw);
    check_val("zero_done", {63'd0, done}, 64'd1);
    check_val("zero_fast", {63'd0, lat <= 4}, 64'd1);
    check_val("zero_no_isq", {63'd0, saw}, 64'd0);
    check_val("zero_data", data_out, 64'd0);
    release_start("zero");

    check_op("half_x", 64'h0000_2000_0000_0000);
    check_val("half_x_exact", data_out, 64'h0000_4000_0000_0000);
    check_op("all_half", 64'h2000_2000_2000_2000);
    check_val("all_half_exact", data_out, 64'h2000_2000_2000_2000);
    check_op("all_one", 64'h4000_4000_4000_4000);
    check_val("all_one_exact", data_out, 64'h2000_2000_2000_2000);
    check_op("max_neg", 64'h8000_8000_8000_8000);
    check_op("small", 64'h0000_0100_0000_0000);

    // reset while waiting on the inverse sqrt
    data_in = 64'h1234_0567_F89A_0BCD;
    start   = 1'b1;
    lat     = 0;
    while ((debug_state != 3'd4) && (lat < MAX_LAT)) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("rst_reach_wait", {61'd0, debug_state}, 64'd4);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_val("rst_state", {61'd0, debug_state}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_data", data_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_val("rst_no_done", {60'd0, done, debug_state}, 64'd0);
    end
    check_op("after_rst", 64'h1234_0567_F89A_0BCD);

    // random quaternions across a range of magnitudes
    for (int n = 0; n < 40; n++) begin
      din = '0;
      for (int i = 0; i < 4; i++) begin
        c = 16'($urandom);
        c = 16'($signed(c) >>> $urandom_range(0, 12));
        din[i*16 +: 16] = c;
      end
      check_op("rand", din);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quaternion_normalisation.md
QUATERNION_NORMALISATION -- requirements
Module: quaternion_normalisation

Interface
REQ-001 SHALL have parameter INPUT_INT_WIDTH, default 2, integer bits (incl. sign) of each signed quaternion component.
REQ-002 SHALL have parameter INPUT_FRACT_WIDTH, default 14, fractional bits of each component; W = INPUT_INT_WIDTH+INPUT_FRACT_WIDTH (16).
REQ-003 SHALL have parameter MAG_SQR_INT_WIDTH, default 4, integer bits of the unsigned magnitude-squared / inverse-sqrt word.
REQ-004 SHALL have parameter MAG_SQR_FRACT_WIDTH, default 12, fractional bits of that word; M = sum (16).
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (async active-low reset).
REQ-006 SHALL have start input 1, level request to normalise data_in.
REQ-007 SHALL have done output 1, result valid, held until start is low.
REQ-008 SHALL have data_in input 4*W, packed {q_w,q_x,q_y,q_z}, q_w in MSBs, two's complement.
REQ-009 SHALL have data_out output 4*W, normalised quaternion, same packing and format.
REQ-010 SHALL have debug_state output 3, current FSM state encoding.

Function
REQ-011 SHALL use FSM states IDLE=0, MAG=1, ROUND=2, ISQ_REQ=3, ISQ_WAIT=4, NORM=5, DONE=6.
REQ-012 IDLE: on start=1, SHALL latch the four components and go to MAG; start is ignored in all other states except DONE.
REQ-013 MAG: SHALL compute mag_sqr = w^2+x^2+y^2+z^2, unsigned, 2W+3 bits, 2*INPUT_FRACT_WIDTH fractional bits, no overflow.
REQ-014 ROUND: SHALL convert mag_sqr to M bits by adding half-LSB then right-shifting (2*INPUT_FRACT_WIDTH - MAG_SQR_FRACT_WIDTH), saturating to all-ones on overflow.
REQ-015 ROUND: if the rounded value is 0, SHALL set data_out = 0 and go directly to DONE (no inverse sqrt).
REQ-016 ISQ_REQ: SHALL drive valid to inv_sqrt with the rounded value, holding it until ready is sampled high, then go to ISQ_WAIT.
REQ-017 ISQ_WAIT: SHALL hold ready high to inv_sqrt and capture its result when its valid is high, then go to NORM.
REQ-018 inv_sqrt result SHALL be 1/sqrt(input) in the same unsigned M-bit format, within 1 LSB, saturated to all-ones; exact for inputs 0.25, 1.0 and 4.0.
REQ-019 NORM: each component SHALL be multiplied (signed x unsigned) by the inverse sqrt into W+M bits.
REQ-020 NORM: each product SHALL be rounded by adding 2^(MAG_SQR_FRACT_WIDTH-1) and arithmetic right-shifting by MAG_SQR_FRACT_WIDTH.
REQ-021 NORM: each rounded product SHALL be saturated to the signed W-bit range.
REQ-022 NORM: SHALL register the rounded, saturated results into data_out and go to DONE.
REQ-023 DONE: SHALL assert done; when start=0, SHALL deassert done next cycle and go to IDLE.
REQ-024 data_out SHALL hold its last value until overwritten by the next NORM or zero-magnitude path.
REQ-025 Total latency from start sampled to done SHALL be at most 8 + inv_sqrt latency cycles; inv_sqrt latency SHALL be at most 40 cycles.
REQ-026 A change of data_in after latching SHALL NOT affect the current operation.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, done=0, data_out=0, debug_state=0, and clear all internal registers and the inv_sqrt handshake.
REQ-028 Reset mid-operation SHALL abort it; no done pulse follows reset release without a new start.

Structure
REQ-029 SHALL keep the default width constants (Q component and Q magnitude-squared int/fract widths) and the FSM state encodings in a shared package/defines file.
REQ-030 SHALL place the inverse square root in one sub-module, inv_sqrt (iterative Newton-Raphson or bit-serial, valid/ready in and out), parameterised by MAG_SQR_INT_WIDTH and MAG_SQR_FRACT_WIDTH.

Verification
REQ-031 Input {0x4000,0xFFEE,0x000A,0xFFEF}, start held -> done; data_out = {0x4000,0xFFEE,0x000A,0xFFEF}.
REQ-032 All-zero input -> done within 4 cycles of start via ROUND; data_out = 0; inv_sqrt never requested.
REQ-033 {0x0000,0x2000,0x0000,0x0000} -> data_out = {0x0000,0x4000,0x0000,0x0000}.
REQ-034 {0x2000,0x2000,0x2000,0x2000} -> data_out unchanged; {0x4000,0x4000,0x4000,0x4000} -> {0x2000,0x2000,0x2000,0x2000}.
REQ-035 Start held high after done -> done stays high, no restart; start low -> done low one cycle later, debug_state=0.
REQ-036 rst_n pulsed low during ISQ_WAIT -> immediately state 0, done=0, data_out=0; next start completes normally.
